exe_stage_pipe: RTL and testbench
=================================

// Module: exe_stage_pipe
// PURPOSE
//  Registered, parametrised execute stage for the ARM-subset core: Val2 generation, ALU, branch target, NZCV.
//  Adds a valid/ready handshake, pipeline output register, flush, and an iterative multi-cycle MUL.
//  Sits between the ID/EXE and EXE/MEM boundaries; stalls upstream while busy or when downstream is blocked.
// PARAMETERS
//  DATA_W        32  datapath width (32 or 64); pc, operands, results
//  MUL_BITS      2   multiplier bits retired per cycle; must divide DATA_W; MUL takes DATA_W/MUL_BITS cycles
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous reset, active-high
//  flush          in   1        kill the in-flight op and output register (branch taken)
//  in_valid       in   1        upstream holds a valid op
//  in_ready       out  1        stage accepts the op this cycle
//  exe_cmd        in   4        ALU command (exe_pkg codes)
//  mem_r_en       in   1        load; Val2 = zero-extended shift_operand
//  mem_w_en       in   1        store; same offset rule as load
//  wb_en, b, s    in   1 each   side-band, registered through unchanged
//  dest           in   4        destination register, registered through
//  pc             in   DATA_W   PC+4 of the op
//  val_rn, val_rm in   DATA_W   operands
//  imm            in   1        shift_operand holds rotate_imm[11:8], imm8[7:0]
//  shift_operand  in   12       shift_imm[11:7], type[6:5], 0[4], Rm index[3:0]
//  signed_imm_24  in   24       branch offset in words
//  sr             in   4        current status {Z,C,V,N}; sr[2] is carry-in
//  out_valid      out  1        output register holds a valid result
//  out_ready      in   1        downstream accepts the result
//  alu_result     out  DATA_W   result
//  br_addr        out  DATA_W   pc + sext(signed_imm_24)<<2, mod 2^DATA_W
//  status         out  4        [3]=Z [2]=C [1]=V [0]=N
//  out_mem_r_en, out_mem_w_en, out_wb_en, out_b, out_s, out_dest, out_val_rm   out   registered copies
//  busy           out  1        multiplier iterating
// BEHAVIOUR
//  Reset: every output register 0; FSM IDLE; in_ready recomputes to 1.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready && !flush.
//  Single-cycle op accepted at edge k: result, flags and side-band visible from edge k, out_valid=1.
//  out_valid clears on out_ready without a new accept; back-to-back ops at 1 per cycle when out_ready=1.
//  Held output (out_valid && !out_ready): every output stable.
//  FSM: IDLE -accept MUL-> MUL (busy=1, in_ready=0) -after DATA_W/MUL_BITS cycles-> IDLE, registering out_valid.
//  Val2: imm -> imm8 rotated right by 2*rotate_imm, zero-extended to DATA_W first;
//   mem_r_en|mem_w_en -> zext(shift_operand) (imm=0); else val_rm shifted by shift_imm: LSL/LSR/ASR/ROR, 0 = no shift.
//  Arithmetic mod 2^DATA_W. ADD/ADC: C = carry out. SUB/SBC: C = NOT borrow; SBC = a-b-!C.
//   V = signed overflow. Logic/MOV/MVN: C, V = sr. N = result msb; Z = result==0.
//  MUL: low DATA_W bits of val_rn*val_rm; N, Z from result; C, V = sr captured at accept.
//  flush: highest priority. Clears out_valid, aborts MUL to IDLE, blocks accept that cycle.
//  flush and out_ready in the same cycle: flush wins.
//  rst mid-MUL: immediate abort, all outputs 0.
//  Undefined exe_cmd: result 0, flags = sr, still handshakes.
// CONFIGURATION
//  EXE_STAGE_MUL_EN defined: MUL path and FSM built as above.
//  Undefined: MUL code is single-cycle with result 0 and status = sr; busy tied 0; no FSM.
// STRUCTURE
//  exe_pkg: EXE_CMD codes (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110,
//   ORR 0111, EOR 1000, MUL 1010), shift type codes, status bit indices, FSM state typedef.
//  Sub-module exe_iter_mul: start/done shift-add multiplier, MUL_BITS per cycle, abort input.
//  Val2 logic and ALU stay inline.
// TESTING
//  ADD 0x7FFFFFFF+1, sr=0 -> out 0x80000000, status N=1 V=1 C=0 Z=0, out_valid one cycle after accept.
//  SUB 5-5 -> 0, Z=1 C=1. SBC 0-0 with sr.C=0 -> 0xFFFFFFFF, N=1 C=0.
//  imm=1, shift_operand=0x4FF -> Val2 0xFF000000. imm=0, ASR #4 of 0x80000000 -> 0xF8000000.
//  STR with shift_operand=0x123 -> Val2 0x123, ignoring val_rm.
//  MUL 0xFFFF*0x10001 -> 0xFFFFFFFF after 16 cycles (MUL_BITS=2), busy high, in_ready low throughout.
//  out_ready=0 for 3 cycles -> outputs frozen, in_ready=0. flush mid-MUL -> out_valid=0, IDLE next cycle.
//  B with signed_imm_24=0xFFFFFF, pc=0x100 -> br_addr 0xFC.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   - EXE_* : ALU command codes carried on exe_cmd
//   - SH_*  : shift type codes found in shift_operand[6:5]
//   - ST_*  : bit positions inside the 4-bit status word {Z,C,V,N}
//   - exe_state_t : execute-stage control FSM states (multiplier build only)
package exe_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int ST_Z = 3;
    localparam int ST_C = 2;
    localparam int ST_V = 1;
    localparam int ST_N = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } exe_state_t;

endpackage

// File: rtl/exe_iter_mul.sv
// exe_iter_mul: iterative shift-add multiplier, MUL_BITS multiplier bits per cycle.
// Only built when EXE_STAGE_MUL_EN is defined.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands and begin iterating (ignored while abort is high)
//   abort         drop the operation in progress
//   a, b          multiplicand / multiplier (sampled on start)
//   done          high during the final iteration cycle; product is valid then
//   product       low DATA_W bits of a*b while done is high
`ifdef EXE_STAGE_MUL_EN
module exe_iter_mul #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic              active;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] partial;

    // Partial product for the low MUL_BITS multiplier bits of this step.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    // product includes the current step so the final value is available
    // combinationally in the done cycle, saving one cycle of latency.
    assign product = acc + partial;
    assign done    = active && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage (Val2, ALU, branch target, NZCV).
// Optional feature macro: EXE_STAGE_MUL_EN builds the iterative MUL path and
// its IDLE/MUL FSM; without it MUL behaves like an undefined command.
// Ports:
//   clk, rst, flush                clock, async active-high reset, pipeline kill
//   in_valid/in_ready              upstream handshake
//   exe_cmd, mem_r_en, mem_w_en,
//   wb_en, b, s, dest, pc, val_rn,
//   val_rm, imm, shift_operand,
//   signed_imm_24, sr              decoded op from ID/EXE
//   out_valid/out_ready            downstream handshake
//   alu_result, br_addr, status,
//   out_* side-band copies         EXE/MEM register contents
//   busy                           multiplier iterating (the FSM is in MUL)
// Handshake: a transfer happens on an edge where valid && ready are both high;
// out_* are held stable while out_valid && !out_ready; flush overrides all.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic              b,
    input  logic              s,
    input  logic [3:0]        dest,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       signed_imm_24,
    input  logic [3:0]        sr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [3:0]        status,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_wb_en,
    output logic              out_b,
    output logic              out_s,
    output logic [3:0]        out_dest,
    output logic [DATA_W-1:0] out_val_rm,
    output logic              busy
);

    logic              idle;
    logic              accept;
    logic              mul_start;
    logic [DATA_W-1:0] imm8_ext;
    logic [4:0]        rot_amt;
    logic [4:0]        sh_amt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic              arith;
    logic              known;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_status;
    logic [DATA_W-1:0] br_off;

    assign in_ready = idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Val2 generation. Rotations are written as two shifts; a shift by
    // DATA_W yields zero, so a zero rotate/shift amount passes the value through.
    always_comb begin
        imm8_ext = DATA_W'(shift_operand[7:0]);
        rot_amt  = {shift_operand[11:8], 1'b0};
        sh_amt   = shift_operand[11:7];
        shifted  = val_rm;
        case (shift_operand[6:5])
            SH_LSL:  shifted = val_rm << sh_amt;
            SH_LSR:  shifted = val_rm >> sh_amt;
            SH_ASR:  shifted = $signed(val_rm) >>> sh_amt;
            SH_ROR:  shifted = (val_rm >> sh_amt) | (val_rm << (DATA_W - int'(sh_amt)));
            default: shifted = val_rm;
        endcase
        if (imm) begin
            val2 = (imm8_ext >> rot_amt) | (imm8_ext << (DATA_W - int'(rot_amt)));
        end else if (mem_r_en || mem_w_en) begin
            val2 = DATA_W'(shift_operand);
        end else begin
            val2 = shifted;
        end
    end

    // ALU: one shared adder; subtraction is a + ~b + cin so the carry out
    // is already the ARM "not borrow".
    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        arith   = 1'b0;
        known   = 1'b1;
        alu_res = '0;
        case (exe_cmd)
            EXE_ADD: arith = 1'b1;
            EXE_ADC: begin arith = 1'b1; add_cin = sr[ST_C]; end
            EXE_SUB: begin arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
            EXE_SBC: begin arith = 1'b1; add_b = ~val2; add_cin = sr[ST_C]; end
            default: ;
        endcase
        sum = {1'b0, val_rn} + {1'b0, add_b} + (DATA_W+1)'(add_cin);
        case (exe_cmd)
            EXE_MOV: alu_res = val2;
            EXE_MVN: alu_res = ~val2;
            EXE_AND: alu_res = val_rn & val2;
            EXE_ORR: alu_res = val_rn | val2;
            EXE_EOR: alu_res = val_rn ^ val2;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: alu_res = sum[DATA_W-1:0];
            default: known = 1'b0;   // MUL (handled separately) and undefined codes
        endcase
        alu_status = sr;
        if (known) begin
            alu_status[ST_Z] = (alu_res == '0);
            alu_status[ST_N] = alu_res[DATA_W-1];
        end
        if (arith) begin
            alu_status[ST_C] = sum[DATA_W];
            alu_status[ST_V] = (val_rn[DATA_W-1] == add_b[DATA_W-1]) &&
                               (alu_res[DATA_W-1] != val_rn[DATA_W-1]);
        end
    end

    assign br_off = {{(DATA_W-24){signed_imm_24[23]}}, signed_imm_24};

`ifdef EXE_STAGE_MUL_EN
    exe_state_t        state_q;
    exe_state_t        state_d;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign mul_start = accept && (exe_cmd == EXE_MUL);
    assign idle      = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_MUL;
            S_MUL:   if (flush || mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    exe_iter_mul #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush),
        .a       (val_rn),
        .b       (val_rm),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_start = 1'b0;
    assign idle      = 1'b1;
    assign busy      = 1'b0;
`endif

    // Output register. A MUL loads side-band, br_addr and C/V (sr) at accept
    // with out_valid low; result, Z and N follow when the multiplier finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            alu_result   <= '0;
            br_addr      <= '0;
            status       <= '0;
            out_mem_r_en <= 1'b0;
            out_mem_w_en <= 1'b0;
            out_wb_en    <= 1'b0;
            out_b        <= 1'b0;
            out_s        <= 1'b0;
            out_dest     <= '0;
            out_val_rm   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= !mul_start;
            alu_result   <= alu_res;
            br_addr      <= pc + (br_off << 2);
            status       <= alu_status;
            out_mem_r_en <= mem_r_en;
            out_mem_w_en <= mem_w_en;
            out_wb_en    <= wb_en;
            out_b        <= b;
            out_s        <= s;
            out_dest     <= dest;
            out_val_rm   <= val_rm;
`ifdef EXE_STAGE_MUL_EN
        end else if (mul_done) begin
            out_valid    <= 1'b1;
            alu_result   <= mul_product;
            status[ST_Z] <= (mul_product == '0);
            status[ST_N] <= mul_product[DATA_W-1];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_pipe.sv
module tb_exe_stage_pipe;
  import exe_pkg::*;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        exe_cmd;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              b;
  logic              s;
  logic [3:0]        dest;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        sr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] br_addr;
  logic [3:0]        status;
  logic              out_mem_r_en;
  logic              out_mem_w_en;
  logic              out_wb_en;
  logic              out_b;
  logic              out_s;
  logic [3:0]        out_dest;
  logic [DATA_W-1:0] out_val_rm;
  logic              busy;

  int n_checks = 0;
  int n_fail = 0;

  exe_stage_pipe #(.DATA_W(DATA_W), .MUL_BITS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .b(b), .s(s), .dest(dest), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .sr(sr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .br_addr(br_addr), .status(status), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en), .out_b(out_b), .out_s(out_s),
    .out_dest(out_dest), .out_val_rm(out_val_rm), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; exe_cmd = 0; mem_r_en = 0; mem_w_en = 0; wb_en = 0;
    b = 0; s = 0; dest = 0; pc = 0; val_rn = 0; val_rm = 0; imm = 0;
    shift_operand = 0; signed_imm_24 = 0; sr = 0; out_ready = 1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic immv, input logic [11:0] so, input logic [3:0] srv);
    in_valid = 1; exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = immv;
    shift_operand = so; sr = srv; mem_r_en = 0; mem_w_en = 0; wb_en = 0;
    b = 0; s = 0; dest = 0; pc = 0; signed_imm_24 = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_alu_result got=%h exp=0", alu_result); end
    n_checks++; if (status !== 4'h0) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", status); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (br_addr !== 32'h0) begin n_fail++; $display("FAIL reset_br_addr got=%h exp=0", br_addr); end
  endtask

  task automatic test_add();
    set_op(EXE_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 12'h000, 4'b0000);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_before got=%b exp=0", out_valid); end
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    n_checks++; if (alu_result !== 32'h80000000) begin n_fail++; $display("FAIL add_result got=%h exp=80000000", alu_result); end
    n_checks++; if (status !== 4'b0011) begin n_fail++; $display("FAIL add_status got=%b exp=0011", status); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_sbc();
    set_op(EXE_SUB, 32'd5, 32'd5, 1'b0, 12'h000, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL sub_result got=%h exp=0", alu_result); end
    n_checks++; if (status !== 4'b1100) begin n_fail++; $display("FAIL sub_status got=%b exp=1100", status); end
    set_op(EXE_SBC, 32'd0, 32'd0, 1'b0, 12'h000, 4'b0000);
    tick();
    in_valid = 0;
    n_checks++; if (alu_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sbc_result got=%h exp=ffffffff", alu_result); end
    n_checks++; if (status !== 4'b0001) begin n_fail++; $display("FAIL sbc_status got=%b exp=0001", status); end
  endtask

  task automatic test_val2();
    // immediate: imm8=0xFF rotated right by 8
    set_op(EXE_MOV, 32'h0, 32'h12345678, 1'b1, 12'h4FF, 4'b0110);
    tick();
    n_checks++; if (alu_result !== 32'hFF000000) begin n_fail++; $display("FAIL imm_rot_result got=%h exp=ff000000", alu_result); end
    n_checks++; if (status !== 4'b0111) begin n_fail++; $display("FAIL imm_rot_status got=%b exp=0111", status); end
    // ASR #4
    set_op(EXE_MOV, 32'h0, 32'h80000000, 1'b0, 12'h240, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'hF8000000) begin n_fail++; $display("FAIL asr_result got=%h exp=f8000000", alu_result); end
    // ROR #4
    set_op(EXE_MOV, 32'h0, 32'h0000000F, 1'b0, 12'h260, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'hF0000000) begin n_fail++; $display("FAIL ror_result got=%h exp=f0000000", alu_result); end
    // LSR #8
    set_op(EXE_MOV, 32'h0, 32'hABCD1200, 1'b0, 12'h420, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'h00ABCD12) begin n_fail++; $display("FAIL lsr_result got=%h exp=00abcd12", alu_result); end
    // store: offset from shift_operand, val_rm ignored for Val2 but registered
    set_op(EXE_MOV, 32'h0, 32'hDEADBEEF, 1'b0, 12'h123, 4'b0000);
    mem_w_en = 1;
    tick();
    in_valid = 0;
    n_checks++; if (alu_result !== 32'h00000123) begin n_fail++; $display("FAIL str_val2 got=%h exp=00000123", alu_result); end
    n_checks++; if (out_mem_w_en !== 1'b1) begin n_fail++; $display("FAIL str_mem_w got=%b exp=1", out_mem_w_en); end
    n_checks++; if (out_val_rm !== 32'hDEADBEEF) begin n_fail++; $display("FAIL str_val_rm got=%h exp=deadbeef", out_val_rm); end
  endtask

  task automatic test_logic();
    set_op(EXE_AND, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'h0F000F00) begin n_fail++; $display("FAIL and_result got=%h exp=0f000f00", alu_result); end
    set_op(EXE_ORR, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'hFF0FFF0F) begin n_fail++; $display("FAIL orr_result got=%h exp=ff0fff0f", alu_result); end
    set_op(EXE_EOR, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 12'h000, 4'b0100);
    tick();
    n_checks++; if (alu_result !== 32'hF00FF00F) begin n_fail++; $display("FAIL eor_result got=%h exp=f00ff00f", alu_result); end
    n_checks++; if (status !== 4'b0101) begin n_fail++; $display("FAIL eor_status got=%b exp=0101", status); end
    set_op(EXE_MVN, 32'h0, 32'hFFFFFFFF, 1'b0, 12'h000, 4'b0000);
    tick();
    n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL mvn_result got=%h exp=0", alu_result); end
    n_checks++; if (status !== 4'b1000) begin n_fail++; $display("FAIL mvn_status got=%b exp=1000", status); end
    set_op(EXE_ADC, 32'h1, 32'h1, 1'b0, 12'h000, 4'b0100);
    tick();
    in_valid = 0;
    n_checks++; if (alu_result !== 32'h3) begin n_fail++; $display("FAIL adc_result got=%h exp=3", alu_result); end
  endtask

  task automatic test_branch();
    set_op(EXE_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 4'b0000);
    pc = 32'h100; signed_imm_24 = 24'hFFFFFF; b = 1; dest = 4'd9; wb_en = 1; s = 1;
    tick();
    n_checks++; if (br_addr !== 32'h000000FC) begin n_fail++; $display("FAIL br_neg got=%h exp=000000fc", br_addr); end
    n_checks++; if (out_b !== 1'b1) begin n_fail++; $display("FAIL br_out_b got=%b exp=1", out_b); end
    n_checks++; if (out_dest !== 4'd9) begin n_fail++; $display("FAIL br_dest got=%0d exp=9", out_dest); end
    n_checks++; if ({out_wb_en, out_s, out_mem_r_en} !== 3'b110) begin n_fail++; $display("FAIL br_sideband got=%b exp=110", {out_wb_en, out_s, out_mem_r_en}); end
    set_op(EXE_MOV, 32'h0, 32'h0, 1'b0, 12'h000, 4'b0000);
    pc = 32'h100; signed_imm_24 = 24'h000010;
    tick();
    in_valid = 0;
    n_checks++; if (br_addr !== 32'h00000140) begin n_fail++; $display("FAIL br_pos got=%h exp=00000140", br_addr); end
  endtask

  task automatic test_undefined();
    set_op(4'b1111, 32'h5, 32'h7, 1'b0, 12'h000, 4'b1010);
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL undef_valid got=%b exp=1", out_valid); end
    n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL undef_result got=%h exp=0", alu_result); end
    n_checks++; if (status !== 4'b1010) begin n_fail++; $display("FAIL undef_status got=%b exp=1010", status); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rn_t [3] = '{32'h1, 32'h100, 32'hFFFFFFFF};
    logic [31:0] rm_t [3] = '{32'h2, 32'h200, 32'h1};
    logic [31:0] ex_t [3] = '{32'h3, 32'h300, 32'h0};
    logic [3:0]  st_t [3] = '{4'b0000, 4'b0000, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      set_op(EXE_ADD, rn_t[i], rm_t[i], 1'b0, 12'h000, 4'b0000);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (alu_result !== ex_t[i]) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, alu_result, ex_t[i]); end
      n_checks++; if (status !== st_t[i]) begin n_fail++; $display("FAIL b2b_status[%0d] got=%b exp=%b", i, status, st_t[i]); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_hold();
    set_op(EXE_ADD, 32'd1, 32'd2, 1'b0, 12'h000, 4'b0000);
    out_ready = 0;
    tick();
    set_op(EXE_ADD, 32'd10, 32'd20, 1'b0, 12'h000, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", c, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b exp=1", c, out_valid); end
      n_checks++; if (alu_result !== 32'd3) begin n_fail++; $display("FAIL hold_result[%0d] got=%h exp=3", c, alu_result); end
    end
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    n_checks++; if (alu_result !== 32'd30) begin n_fail++; $display("FAIL hold_next_result got=%h exp=1e", alu_result); end
    tick();
  endtask

  task automatic test_flush();
    set_op(EXE_ADD, 32'd100, 32'd200, 1'b0, 12'h000, 4'b0000);
    out_ready = 0;
    tick();
    set_op(EXE_ADD, 32'd7, 32'd8, 1'b0, 12'h000, 4'b0000);
    out_ready = 1;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_checks++; if (alu_result !== 32'd300) begin n_fail++; $display("FAIL flush_blocks_accept got=%h exp=12c", alu_result); end
    tick();
  endtask

  task automatic test_mul();
    set_op(EXE_MUL, 32'h0000FFFF, 32'h00010001, 1'b0, 12'h000, 4'b0110);
    tick();
    in_valid = 0;
`ifdef EXE_STAGE_MUL_EN
    for (int c = 0; c < 16; c++) begin
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy[%0d] got=%b exp=1", c, busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready[%0d] got=%b exp=0", c, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_early[%0d] got=%b exp=0", c, out_valid); end
      tick();
    end
`endif
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid got=%b exp=1", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_done got=%b exp=0", busy); end
`ifdef EXE_STAGE_MUL_EN
    n_checks++; if (alu_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_result got=%h exp=ffffffff", alu_result); end
    n_checks++; if (status !== 4'b0111) begin n_fail++; $display("FAIL mul_status got=%b exp=0111", status); end
`else
    n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL mul_off_result got=%h exp=0", alu_result); end
    n_checks++; if (status !== 4'b0110) begin n_fail++; $display("FAIL mul_off_status got=%b exp=0110", status); end
`endif
    tick();
  endtask

`ifdef EXE_STAGE_MUL_EN
  task automatic test_flush_mul();
    set_op(EXE_MUL, 32'd3, 32'd4, 1'b0, 12'h000, 4'b0000);
    tick();
    in_valid = 0;
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_mul_busy got=%b exp=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_mul_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_mul_ready got=%b exp=1", in_ready); end
    repeat (20) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_mul_no_late_result got=%b exp=0", out_valid); end
  endtask
`endif

  task automatic test_reset_mid_op();
    set_op(EXE_MUL, 32'd6, 32'd7, 1'b0, 12'h000, 4'b1111);
    dest = 4'd5;
    out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    #2;
    rst = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_checks++; if (out_dest !== 4'd0) begin n_fail++; $display("FAIL rst_mid_dest got=%0d exp=0", out_dest); end
    n_checks++; if (status !== 4'd0) begin n_fail++; $display("FAIL rst_mid_status got=%b exp=0000", status); end
    tick();
    rst = 0;
    out_ready = 1;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    test_reset();
    rst = 0;
    test_add();
    test_sub_sbc();
    test_val2();
    test_logic();
    test_branch();
    test_undefined();
    test_back_to_back();
    test_hold();
    test_flush();
    test_mul();
`ifdef EXE_STAGE_MUL_EN
    test_flush_mul();
`endif
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
